// File: rtl/seg_disp_pkg.sv
// Shared glyph constants and polarity helpers for the multiplexed
// 7-segment display controller. Glyphs are {a,b,c,d,e,f,g}, active-high.
package seg_disp_pkg;

   localparam int MAX_DIGITS = 16;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_B     = 7'b0011111;
   localparam logic [6:0] SEG_C     = 7'b1001110;
   localparam logic [6:0] SEG_D     = 7'b0111101;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_F     = 7'b1000111;

   // Map an active-high {a..g,dp} bus onto the board polarity.
   function automatic logic [7:0] seg_pol(
      input logic [7:0] segs,
      input bit         active_low
   );
      return active_low ? ~segs : segs;
   endfunction

   // Value of the segment bus with everything dark.
   function automatic logic [7:0] seg_off(input bit active_low);
      return seg_pol(8'h00, active_low);
   endfunction

endpackage

// File: rtl/seg_scan_display_ctrl_if.sv
// Load port of the display controller: nibble word, dp/blink masks and
// mode bits, qualified by a valid/ready handshake.
//  master: load source, slave: display controller.
interface seg_scan_display_ctrl_if #(
   parameter int NUM_DIGITS = 8
);

   logic [4*NUM_DIGITS-1:0] data_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blink_in;
   logic                    lzb_en;
   logic                    hex_mode;
   logic                    load_valid;
   logic                    load_ready;

   modport master (
      output data_in,
      output dp_in,
      output blink_in,
      output lzb_en,
      output hex_mode,
      output load_valid,
      input  load_ready
   );

   modport slave (
      input  data_in,
      input  dp_in,
      input  blink_in,
      input  lzb_en,
      input  hex_mode,
      input  load_valid,
      output load_ready
   );

endinterface

// File: rtl/seg_glyph_decoder.sv
// Nibble to active-high {a..g} glyph. In decimal mode nibbles A-F blank.
//  nibble_i, hex_mode_i in; segs_o out (combinational).
module seg_glyph_decoder
   import seg_disp_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       hex_mode_i,
   output logic [6:0] segs_o
);

   logic [6:0] hex_glyph;

   always_comb begin
      hex_glyph = SEG_BLANK;
      unique case (nibble_i)
         4'h0: hex_glyph = SEG_0;
         4'h1: hex_glyph = SEG_1;
         4'h2: hex_glyph = SEG_2;
         4'h3: hex_glyph = SEG_3;
         4'h4: hex_glyph = SEG_4;
         4'h5: hex_glyph = SEG_5;
         4'h6: hex_glyph = SEG_6;
         4'h7: hex_glyph = SEG_7;
         4'h8: hex_glyph = SEG_8;
         4'h9: hex_glyph = SEG_9;
         4'hA: hex_glyph = SEG_A;
         4'hB: hex_glyph = SEG_B;
         4'hC: hex_glyph = SEG_C;
         4'hD: hex_glyph = SEG_D;
         4'hE: hex_glyph = SEG_E;
         4'hF: hex_glyph = SEG_F;
      endcase
   end

   always_comb begin
      segs_o = hex_glyph;
      if (!hex_mode_i && (nibble_i > 4'h9)) begin
         segs_o = SEG_BLANK;
      end
   end

endmodule

// File: rtl/seg_scan_display_ctrl.sv
// Multiplexed N-digit 7-segment controller with frame-synchronous
// double buffering, leading-zero blanking, PWM brightness and blink.
//  sys_clk_in, reset (async, active-low); load_if: load port (slave);
//  brightness in; display_out {a..g,dp}, seg_control, frame_sync out.
module seg_scan_display_ctrl
   import seg_disp_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int SCAN_DIV_LOG2  = 10,
   parameter int BRIGHT_W       = 3,
   parameter int BLINK_LOG2     = 24,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                  sys_clk_in,
   input  logic                  reset,
   seg_scan_display_ctrl_if.slave load_if,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [7:0]            display_out,
   output logic [NUM_DIGITS-1:0] seg_control,
   output logic                  frame_sync
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [7:0] SEG_OFF = seg_off(SEG_ACTIVE_LOW);
   localparam logic [NUM_DIGITS-1:0] DIG_OFF =
      DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   // scan state
   logic [SCAN_DIV_LOG2-1:0] presc_q, presc_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [BLINK_LOG2-1:0]    blink_cnt_q, blink_cnt_d;
   logic [BRIGHT_W-1:0]      bright_q, bright_d;

   // shadow (load side) and active (scan side) buffers
   logic [NUM_DIGITS-1:0][3:0] sh_nib_q, sh_nib_d;
   logic [NUM_DIGITS-1:0]      sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]      sh_blink_q, sh_blink_d;
   logic                       sh_lzb_q, sh_lzb_d;
   logic                       sh_hex_q, sh_hex_d;
   logic [NUM_DIGITS-1:0][3:0] act_nib_q, act_nib_d;
   logic [NUM_DIGITS-1:0]      act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]      act_blink_q, act_blink_d;
   logic                       act_lzb_q, act_lzb_d;
   logic                       act_hex_q, act_hex_d;
   logic                       pending_q, pending_d;

   // output flops
   logic [7:0]            disp_q, disp_d;
   logic [NUM_DIGITS-1:0] segc_q, segc_d;
   logic                  fsync_q, fsync_d;

   logic tick;
   logic frame_end;
   logic capture;
   logic commit;

   assign tick      = &presc_q;
   assign frame_end = tick && (idx_q == LAST_IDX);
   assign capture   = load_if.load_valid && !pending_q;
   assign commit    = frame_end && pending_q;

   assign load_if.load_ready = !pending_q;

   always_comb begin
      presc_d     = presc_q + SCAN_DIV_LOG2'(1);
      blink_cnt_d = blink_cnt_q + BLINK_LOG2'(1);
      idx_d       = idx_q;
      bright_d    = bright_q;
      if (tick) begin
         idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
         // new level takes effect for the whole upcoming slot
         bright_d = brightness;
      end
   end

   always_comb begin
      sh_nib_d    = sh_nib_q;
      sh_dp_d     = sh_dp_q;
      sh_blink_d  = sh_blink_q;
      sh_lzb_d    = sh_lzb_q;
      sh_hex_d    = sh_hex_q;
      act_nib_d   = act_nib_q;
      act_dp_d    = act_dp_q;
      act_blink_d = act_blink_q;
      act_lzb_d   = act_lzb_q;
      act_hex_d   = act_hex_q;
      pending_d   = pending_q;
      if (commit) begin
         act_nib_d   = sh_nib_q;
         act_dp_d    = sh_dp_q;
         act_blink_d = sh_blink_q;
         act_lzb_d   = sh_lzb_q;
         act_hex_d   = sh_hex_q;
         pending_d   = 1'b0;
      end
      // capture and commit are exclusive: capture needs !pending
      if (capture) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            sh_nib_d[i]   = load_if.data_in[4*(NUM_DIGITS-1-i) +: 4];
            sh_dp_d[i]    = load_if.dp_in[NUM_DIGITS-1-i];
            sh_blink_d[i] = load_if.blink_in[NUM_DIGITS-1-i];
         end
         sh_lzb_d  = load_if.lzb_en;
         sh_hex_d  = load_if.hex_mode;
         pending_d = 1'b1;
      end
   end

   // glyph path: one decoder shared by all digits via idx mux
   logic [3:0]            cur_nib;
   logic [6:0]            glyph;
   logic [NUM_DIGITS-1:0] lead_zero;
   logic                  zero_run;
   logic                  lzb_blank;
   logic                  dark;
   logic [6:0]            segs_on;
   logic                  dp_on;

   assign cur_nib = act_nib_q[idx_q];

   seg_glyph_decoder u_glyph (
      .nibble_i   (cur_nib),
      .hex_mode_i (act_hex_q),
      .segs_o     (glyph)
   );

   // lead_zero[i]: digit i and every digit left of it are zero
   always_comb begin
      zero_run  = 1'b1;
      lead_zero = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         zero_run     = zero_run && (act_nib_q[i] == 4'h0);
         lead_zero[i] = zero_run;
      end
   end

   // the rightmost digit always shows, so an all-zero value reads "0"
   assign lzb_blank = act_lzb_q && lead_zero[idx_q] && (idx_q != LAST_IDX);
   assign dark      = act_blink_q[idx_q] && blink_cnt_q[BLINK_LOG2-1];
   assign segs_on   = (lzb_blank || dark) ? SEG_BLANK : glyph;
   assign dp_on     = act_dp_q[idx_q] && !dark;

   // enable: dead cycle at slot start, then PWM against prescaler top bits
   logic                  bright_hit;
   logic                  dig_on;
   logic [NUM_DIGITS-1:0] en_vec;

   assign bright_hit = (&bright_q) ||
      (presc_q[SCAN_DIV_LOG2-1 -: BRIGHT_W] < bright_q);
   assign dig_on = (presc_q != '0) && bright_hit;

   always_comb begin
      en_vec = '0;
      if (dig_on) begin
         en_vec[idx_q] = 1'b1;
      end
   end

   always_comb begin
      disp_d  = seg_pol({segs_on, dp_on}, SEG_ACTIVE_LOW);
      segc_d  = DIG_ACTIVE_LOW ? ~en_vec : en_vec;
      fsync_d = commit;
   end

   always_ff @(posedge sys_clk_in or negedge reset) begin
      if (!reset) begin
         presc_q     <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         bright_q    <= '0;
         sh_nib_q    <= '0;
         sh_dp_q     <= '0;
         sh_blink_q  <= '0;
         sh_lzb_q    <= 1'b0;
         sh_hex_q    <= 1'b0;
         act_nib_q   <= '0;
         act_dp_q    <= '0;
         act_blink_q <= '0;
         act_lzb_q   <= 1'b0;
         act_hex_q   <= 1'b0;
         pending_q   <= 1'b0;
         disp_q      <= SEG_OFF;
         segc_q      <= DIG_OFF;
         fsync_q     <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         bright_q    <= bright_d;
         sh_nib_q    <= sh_nib_d;
         sh_dp_q     <= sh_dp_d;
         sh_blink_q  <= sh_blink_d;
         sh_lzb_q    <= sh_lzb_d;
         sh_hex_q    <= sh_hex_d;
         act_nib_q   <= act_nib_d;
         act_dp_q    <= act_dp_d;
         act_blink_q <= act_blink_d;
         act_lzb_q   <= act_lzb_d;
         act_hex_q   <= act_hex_d;
         pending_q   <= pending_d;
         disp_q      <= disp_d;
         segc_q      <= segc_d;
         fsync_q     <= fsync_d;
      end
   end

   assign display_out = disp_q;
   assign seg_control = segc_q;
   assign frame_sync  = fsync_q;

endmodule

// File: tb/tb_seg_scan_display_ctrl.sv
// Directed bench for seg_scan_display_ctrl: 4 digits, 16-cycle slots,
// 2-bit brightness, 256-cycle blink period, active-low outputs.
`timescale 1ns/1ps
module tb_seg_scan_display_ctrl;

   localparam int ND = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] brightness;
   logic [7:0] display_out;
   logic [3:0] seg_control;
   logic       frame_sync;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc;

   seg_scan_display_ctrl_if #(.NUM_DIGITS(ND)) lif ();

   seg_scan_display_ctrl #(
      .NUM_DIGITS     (ND),
      .SCAN_DIV_LOG2  (4),
      .BRIGHT_W       (2),
      .BLINK_LOG2     (8),
      .SEG_ACTIVE_LOW (1'b1),
      .DIG_ACTIVE_LOW (1'b1)
   ) dut (
      .sys_clk_in  (clk),
      .reset       (rst_n),
      .load_if     (lif),
      .brightness  (brightness),
      .display_out (display_out),
      .seg_control (seg_control),
      .frame_sync  (frame_sync)
   );

   always #5 clk = ~clk;

   // clocks since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                          input logic [3:0] bl, input logic lzb,
                          input logic hex);
      int n = 0;
      lif.data_in    = d;
      lif.dp_in      = dp;
      lif.blink_in   = bl;
      lif.lzb_en     = lzb;
      lif.hex_mode   = hex;
      lif.load_valid = 1'b1;
      while (lif.load_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("load_ready", {31'd0, lif.load_ready}, 1);
      @(negedge clk);
      lif.load_valid = 1'b0;
   endtask

   task automatic wait_fs(input string tag);
      int n = 0;
      while (frame_sync !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_fs"}, {31'd0, frame_sync}, 1);
   endtask

   // call at the negedge where frame_sync is high (presc=0, idx=0)
   task automatic check_frame(input string tag, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input int b);
      logic [7:0] exp_d [4];
      logic [3:0] one_hot;
      logic [3:0] exp_s;
      int         s, d, p;
      bit         en;
      exp_d = '{e0, e1, e2, e3};
      for (int j = 1; j <= 64; j++) begin
         @(negedge clk);
         s = j - 1;
         d = s / 16;
         p = s % 16;
         if (p == 8) begin
            check($sformatf("%s_disp%0d", tag, d),
                  {24'd0, display_out}, {24'd0, exp_d[d]});
         end
         if (p == 0 || p == 1 || p == 3 || p == 4 || p == 15) begin
            en      = (p != 0) && (b == 3 || (p >> 2) < b);
            one_hot = 4'b0001 << d;
            exp_s   = en ? ~one_hot : 4'hF;
            check($sformatf("%s_en%0d_p%0d", tag, d, p),
                  {28'd0, seg_control}, {28'd0, exp_s});
         end
      end
   endtask

   initial begin
      int seen;
      int s;
      bit ph;
      lif.data_in    = '0;
      lif.dp_in      = '0;
      lif.blink_in   = '0;
      lif.lzb_en     = 1'b0;
      lif.hex_mode   = 1'b0;
      lif.load_valid = 1'b0;
      brightness     = 2'd3;

      repeat (3) @(negedge clk);
      check("rst_disp", {24'd0, display_out}, 32'hFF);
      check("rst_segc", {28'd0, seg_control}, 32'hF);
      check("rst_ready", {31'd0, lif.load_ready}, 1);
      check("rst_fs", {31'd0, frame_sync}, 0);
      rst_n = 1'b1;

      // basic digits with a decimal point
      do_load(16'h1234, 4'b0100, 4'b0000, 1'b0, 1'b1);
      wait_fs("t2");
      check_frame("t2", 8'h9F, 8'h24, 8'h0D, 8'h99, 3);

      // reset mid-scan with a load pending
      repeat (21) @(negedge clk);
      do_load(16'h5555, 4'b0000, 4'b0000, 1'b0, 1'b1);
      check("mid_busy", {31'd0, lif.load_ready}, 0);
      #3 rst_n = 1'b0;
      #1;
      check("mid_disp", {24'd0, display_out}, 32'hFF);
      check("mid_segc", {28'd0, seg_control}, 32'hF);
      check("mid_ready", {31'd0, lif.load_ready}, 1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (frame_sync) seen++;
      end
      check("lost_load", seen, 0);

      // leading-zero blanking
      do_load(16'h0050, 4'b0000, 4'b0000, 1'b1, 1'b1);
      wait_fs("lzb1");
      check_frame("lzb1", 8'hFF, 8'hFF, 8'h49, 8'h03, 3);
      do_load(16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
      wait_fs("lzb2");
      check_frame("lzb2", 8'hFF, 8'hFF, 8'hFF, 8'h03, 3);

      // back-to-back loads, no tearing
      do_load(16'hAAAA, 4'b0000, 4'b0000, 1'b0, 1'b1);
      lif.data_in    = 16'h5555;
      lif.load_valid = 1'b1;
      check("bb_busy", {31'd0, lif.load_ready}, 0);
      wait_fs("bb1");
      check("bb_rdy", {31'd0, lif.load_ready}, 1);
      fork
         check_frame("bbA", 8'h11, 8'h11, 8'h11, 8'h11, 3);
         begin
            @(negedge clk);
            lif.load_valid = 1'b0;
         end
      join
      wait_fs("bb2");
      check_frame("bb5", 8'h49, 8'h49, 8'h49, 8'h49, 3);

      // decimal vs hex glyph mode
      do_load(16'hA9A0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      wait_fs("dec");
      check_frame("dec", 8'hFF, 8'h09, 8'hFF, 8'h03, 3);
      do_load(16'hA9A0, 4'b0000, 4'b0000, 1'b0, 1'b1);
      wait_fs("hex");
      check_frame("hex", 8'h11, 8'h09, 8'h11, 8'h03, 3);

      // brightness
      brightness = 2'd0;
      do_load(16'h1234, 4'b0100, 4'b0000, 1'b0, 1'b1);
      wait_fs("br0");
      check_frame("br0", 8'h9F, 8'h24, 8'h0D, 8'h99, 0);
      brightness = 2'd1;
      do_load(16'h1234, 4'b0100, 4'b0000, 1'b0, 1'b1);
      wait_fs("br1");
      check_frame("br1", 8'h9F, 8'h24, 8'h0D, 8'h99, 1);

      // blink on digit 1 over a full blink period
      brightness = 2'd3;
      do_load(16'h1234, 4'b0100, 4'b0100, 1'b0, 1'b1);
      wait_fs("blk");
      for (int j = 1; j <= 256; j++) begin
         @(negedge clk);
         s  = (j - 1) % 64;
         ph = (((cyc - 1) >> 7) & 1) != 0;
         if (s == 20) begin
            check($sformatf("blink_d1_j%0d", j), {24'd0, display_out},
                  ph ? 32'hFF : 32'h24);
         end
         if (s == 4) begin
            check($sformatf("blink_d0_j%0d", j), {24'd0, display_out},
                  32'h9F);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
